// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: start/busy/done handshake and operand/result bus
interface nibble_serial_adder_ctrl_if #(parameter int NIBBLES = 4);
  logic start;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic busy;
  logic done;
  logic [4*NIBBLES-1:0] sum;
  logic cout;
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide unsigned add by sequencing one 4-bit slice LSB-first
module nibble_serial_adder_ctrl #(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int W = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES)+1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q, sum_q;
  logic [IW-1:0] idx;
  logic carry, cout_q, last;
  logic [4:0] slice;
  assign slice = {1'b0, a_q[4*idx+:4]} + {1'b0, b_q[4*idx+:4]} + {4'b0, carry};
  assign last = idx == IW'(NIBBLES-1);
  always_comb begin
    state_n = (state == IDLE) ? (bus.start ? ADD : IDLE) :
              (state == ADD) ? (last ? DONE : ADD) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx <= '0;
      carry <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        a_q <= bus.a;
        b_q <= bus.b;
        sum_q <= '0;
        idx <= '0;
        carry <= 1'b0;
      end
      if (state == ADD) begin
        sum_q[4*idx+:4] <= slice[3:0];
        carry <= slice[4];
        if (last) cout_q <= slice[4];
        else idx <= idx + IW'(1);
      end
    end
  end
  assign bus.busy = state == ADD;
  assign bus.done = state == DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle controller that computes a wide unsigned sum by sequencing one 4-bit ripple-adder slice over successive nibbles. It is LSB-first and carries between nibbles in a register. It sits beside the 4-bit adder in the counter/arithmetic datapath and is how the team builds 8/16/32-bit additions without widening the adder. It uses a start/busy/done handshake and holds its result until the next accepted start.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..8.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A; captured on the accepting edge.
- b  input  W  operand B; captured on the accepting edge.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse; result valid.
- sum  output  W  result register.
- cout  output  1  carry out of the top nibble.

## Operation
- Internal registers:
  - a_q, b_q (W bits each): operand copies.
  - idx: ceil(log2(NIBBLES))+1 bits.
  - carry: 1 bit.
  - sum_q: W bits.
  - cout_q: 1 bit.
  - state: one of IDLE, ADD, DONE.
- Slice arithmetic: {c_next, s_nib} = a_q[4*idx+:4] + b_q[4*idx+:4] + carry, computed as a 5-bit result.
  - s_nib is written into sum_q[4*idx+:4].
  - carry <= c_next.
- IDLE:
  - If start=1: latch a/b, clear carry, set idx to 0, clear sum_q, and go to ADD.
  - Otherwise stay in IDLE.
  - sum/cout keep their previous values.
- ADD:
  - One nibble is processed per cycle.
  - If idx == NIBBLES-1: cout_q <= c_next and go to DONE.
  - Otherwise idx <= idx+1.
- DONE: done=1 for this cycle only, then go unconditionally to IDLE.
- start is ignored in ADD and DONE. There is no queuing; the requester must retry in IDLE.
- Operand changes after acceptance have no effect on the operation in progress.
- The result is the modulo-2^W sum; cout is bit W of a+b.
- rst asserted at any time, including mid-ADD, does all of the following immediately:
  - state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, idx=0.
  - The in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- Let edge E be the edge that samples start=1 in IDLE.
  - busy rises after edge E.
  - Nibble k is written at edge E+1+k.
- After edge E+NIBBLES:
  - state is DONE and busy=0.
  - done=1 for exactly one cycle.
  - sum and cout are final.
- Latency: start-accept to done = NIBBLES+1 cycles. Throughput: one operation per NIBBLES+2 cycles.
- sum/cout are registered outputs.
  - During ADD, low nibbles of sum update progressively. Consumers read only when done=1 or later.
  - Values hold until the edge after the next accepted start, at which point sum clears to 0.
- done and busy are never high in the same cycle.
- A start held high continuously is re-accepted on the first IDLE cycle after DONE (back-to-back operation).

## Test plan
All scenarios use NIBBLES=4 unless stated.
- Reset: assert rst mid-ADD after 2 nibbles -> busy, done, sum and cout drop to 0 asynchronously. After release, a new start with 0x0001+0x0001 gives sum=0x0002, cout=0.
- Basic, no inter-nibble carry: 0x1234+0x4321 -> done exactly 5 cycles after start is accepted; sum=0x5555, cout=0; busy high for exactly 4 cycles.
- Full carry ripple across all nibbles: 0xFFFF+0x0001 -> sum=0x0000, cout=1.
- Max operands: 0xFFFF+0xFFFF -> sum=0xFFFE, cout=1.
- Handshake boundaries:
  - Pulse start again during busy with different operands -> ignored; the first result is unchanged.
  - Hold start high with 0x00FF+0x0001 -> two consecutive results of 0x0100, done pulses 6 cycles apart.
  - Change a/b mid-ADD -> result still reflects the latched operands.
- Parameter corners:
  - NIBBLES=1: 0xF+0x1 -> sum=0x0, cout=1, done 2 cycles after accept.
  - NIBBLES=8: 0x80000000+0x80000000 -> sum=0, cout=1.
